// File: rtl/register_file_mrnw.sv
// register_file_mrnw: NUM_READ combinational read ports, NUM_WRITE byte-enabled write ports, hardware clear sweep after reset.
// Latency: a write presented in cycle N commits at the end of N+1 and is readable in N+2 (N+1 with RF_BYPASS_EN).
// Backpressure: none; writes that are not accepted (not ready, out of range, no byte enables) are dropped. Optional macro: RF_BYPASS_EN.
module register_file_mrnw #(
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WORDS  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  output logic                                     init_done_o,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]      raddr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]      rdata_o,
  input  logic [NUM_WRITE-1:0]                     we_i,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]     waddr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH/8-1:0]   wbe_i
);

  localparam int                  NB          = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] NUM_WORDS_W = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               cnt_q, cnt_d;
  logic                                init_done;
  logic                                sweep_en;

  logic [NUM_WRITE-1:0]                wr_acc;
  logic [NUM_WRITE-1:0]                stg_vld_q, stg_vld_d;
  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] stg_addr_q, stg_addr_d;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] stg_dat_q, stg_dat_d;
  logic [NUM_WRITE-1:0][NB-1:0]        stg_be_q, stg_be_d;

  logic [DATA_WIDTH-1:0]               mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0]               mem_d [NUM_WORDS];
  logic [NUM_WORDS-1:0]                word_en;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NUM_WORDS_W;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // FSM next state: leave INIT once the last word has been swept
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (cnt_q == LAST_IDX) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    init_done = 1'b0;
    sweep_en  = 1'b0;
    case (state_q)
      ST_INIT:  sweep_en  = 1'b1;
      ST_READY: init_done = 1'b1;
      default:  sweep_en  = 1'b0;
    endcase
  end

  assign init_done_o = init_done;

  // sweep counter advances one word per cycle while clearing
  always_comb begin
    cnt_d = cnt_q;
    if (sweep_en && (cnt_q != LAST_IDX)) cnt_d = cnt_q + 1'b1;
  end

  // sweep counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // write accept and stage capture; payload only reloads on an accepted write
  always_comb begin
    for (int p = 0; p < NUM_WRITE; p++) begin
      wr_acc[p]     = we_i[p] && init_done && in_range(waddr_i[p]) && (wbe_i[p] != '0);
      stg_vld_d[p]  = wr_acc[p];
      stg_addr_d[p] = wr_acc[p] ? waddr_i[p] : stg_addr_q[p];
      stg_dat_d[p]  = wr_acc[p] ? wdata_i[p] : stg_dat_q[p];
      stg_be_d[p]   = wr_acc[p] ? wbe_i[p]   : stg_be_q[p];
    end
  end

  // stage registers; reset drops anything staged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld_q  <= '0;
      stg_addr_q <= '0;
      stg_dat_q  <= '0;
      stg_be_q   <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_addr_q <= stg_addr_d;
      stg_dat_q  <= stg_dat_d;
      stg_be_q   <= stg_be_d;
    end
  end

  // next word values and per-word gate enables: sweep clear, else byte merge with higher port winning
  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      mem_d[w]   = mem_q[w];
      word_en[w] = 1'b0;
      if (sweep_en) begin
        if (cnt_q == ADDR_WIDTH'(w)) begin
          word_en[w] = 1'b1;
          mem_d[w]   = '0;
        end
      end else begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (stg_vld_q[p] && (stg_addr_q[p] == ADDR_WIDTH'(w))) begin
            word_en[w] = 1'b1;
            for (int b = 0; b < NB; b++) begin
              if (stg_be_q[p][b]) mem_d[w][8*b +: 8] = stg_dat_q[p][8*b +: 8];
            end
          end
        end
      end
      // an edge with reset asserted must not commit the staged write it is discarding
      word_en[w] = word_en[w] & rst_n;
    end
  end

  // storage: word_en is the enable of each word's clock gate; storage itself is never reset
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (word_en[w]) mem_q[w] <= mem_d[w];
    end
  end

  // combinational read ports, forced to zero until cleared or when out of range
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rdata_o[r] = '0;
      if (init_done && in_range(raddr_i[r])) begin
        rdata_o[r] = mem_q[raddr_i[r]];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (stg_vld_q[p] && (stg_addr_q[p] == raddr_i[r])) begin
            for (int b = 0; b < NB; b++) begin
              if (stg_be_q[p][b]) rdata_o[r][8*b +: 8] = stg_dat_q[p][8*b +: 8];
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_mrnw.sv
// Randomized and directed bench for register_file_mrnw (24 words, 5-bit address).
// Reference model: word array plus one cycle of pending writes, readiness from edge count since release.
// Works with and without RF_BYPASS_EN defined.
`timescale 1ns/1ps
module tb_register_file_mrnw;
  localparam int NR = 3, NWR = 2, AW = 5, NWD = 24, DW = 32, NB = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     init_done;
  logic [NR-1:0][AW-1:0]    raddr;
  logic [NR-1:0][DW-1:0]    rdata;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   waddr;
  logic [NWR-1:0][DW-1:0]   wdata;
  logic [NWR-1:0][NB-1:0]   wbe;

  always #5 clk = ~clk;

  register_file_mrnw #(
    .NUM_READ(NR), .NUM_WRITE(NWR), .ADDR_WIDTH(AW), .NUM_WORDS(NWD), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done_o(init_done),
    .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] m_mem [NWD];
  bit            m_ready = 1'b0;
  int            m_rel   = 0;
  bit            pv [NWR];
  logic [AW-1:0] pa [NWR];
  logic [DW-1:0] pd [NWR];
  logic [NB-1:0] pb [NWR];

  logic          obs_done;
  logic [DW-1:0] obs_rd [NR];
  logic [AW-1:0] last_wa;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [NB-1:0] be);
    logic [DW-1:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!m_ready || a >= NWD) return '0;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    for (int p = 0; p < NWR; p++)
      if (pv[p] && pa[p] == a) v = merge(v, pd[p], pb[p]);
`endif
    return v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_ready = 1'b0;
      m_rel   = 0;
      for (int p = 0; p < NWR; p++) pv[p] = 1'b0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (pv[p]) m_mem[pa[p]] = merge(m_mem[pa[p]], pd[p], pb[p]);
      for (int p = 0; p < NWR; p++) begin
        pv[p] = we[p] && m_ready && (waddr[p] < NWD) && (wbe[p] != 0);
        pa[p] = waddr[p];
        pd[p] = wdata[p];
        pb[p] = wbe[p];
      end
      m_rel++;
      if (!m_ready && m_rel >= NWD) begin
        m_ready = 1'b1;
        for (int w = 0; w < NWD; w++) m_mem[w] = '0;
      end
    end
  endtask

  // called just after a falling edge with inputs already driven
  task automatic cycle();
    #1;
    obs_done = init_done;
    check_val("init_done", {31'b0, init_done}, {31'b0, m_ready});
    for (int r = 0; r < NR; r++) begin
      obs_rd[r] = rdata[r];
      check_val($sformatf("rdata%0d_a%0d", r, raddr[r]), rdata[r], exp_read(raddr[r]));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = '0; wbe = '0; waddr = '0; wdata = '0;
    for (int r = 0; r < NR; r++) raddr[r] = AW'($urandom_range(0, 31));
  endtask

  task automatic rnd_in();
    for (int p = 0; p < NWR; p++) begin
      we[p]    = 1'($urandom_range(0, 1));
      waddr[p] = AW'($urandom_range(0, 31));
      wdata[p] = $urandom;
      wbe[p]   = NB'($urandom_range(0, 15));
    end
    for (int r = 0; r < NR; r++) raddr[r] = AW'($urandom_range(0, 31));
    // re-read last cycle's write target to exercise read-after-write timing
    raddr[0] = last_wa;
    last_wa  = waddr[0];
  endtask

  task automatic read_all();
    for (int a = 0; a < NWD; a += NR) begin
      idle();
      for (int r = 0; r < NR; r++) raddr[r] = AW'(a + r);
      cycle();
    end
  endtask

  task automatic all_raddr(input logic [AW-1:0] a);
    for (int r = 0; r < NR; r++) raddr[r] = a;
  endtask

  // release reset and count cycles until init_done is seen; optional one-cycle reset glitch
  task automatic release_wait(input int glitch_at);
    int k, guard, g;
    g = glitch_at; k = 0; guard = 0;
    rst_n = 1'b1;
    while (guard < 200) begin
      guard++;
      rnd_in();
      if (k == 5) begin
        we = '1; wbe = '1;
        waddr[0] = 5'd2; wdata[0] = 32'h1111_2222;
        waddr[1] = 5'd3; wdata[1] = 32'h3333_4444;
      end
      if (k == g) rst_n = 1'b0;
      cycle();
      if (k == g) begin
        rst_n = 1'b1; k = 0; g = -1;
      end else if (obs_done) begin
        break;
      end else begin
        k++;
      end
    end
    check_val("init_rise_cycle", k, NWD);
  endtask

  initial begin
    for (int w = 0; w < NWD; w++) m_mem[w] = '0;
    for (int p = 0; p < NWR; p++) begin pv[p] = 0; pa[p] = '0; pd[p] = '0; pb[p] = '0; end
    last_wa = '0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    repeat (3) begin rnd_in(); cycle(); end

    // clear sweep, write attempt during sweep is dropped, every word reads zero
    release_wait(-1);
    read_all();

    // same-cycle same-address priority
    idle(); all_raddr(5'd7);
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[0] = 32'hAAAA_AAAA; wbe[0] = 4'hF;
    wdata[1] = 32'h5555_5555; wbe[1] = 4'h3;
    cycle();
    idle(); all_raddr(5'd7); cycle();
    idle(); all_raddr(5'd7); cycle();
    check_val("prio_addr7", obs_rd[0], 32'hAAAA_5555);

    // read latency on address 3
    idle(); all_raddr(5'd3);
    we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'h1234_5678; wbe[0] = 4'hF;
    cycle();
    idle(); all_raddr(5'd3); cycle();
`ifdef RF_BYPASS_EN
    check_val("lat_n1", obs_rd[1], 32'h1234_5678);
`else
    check_val("lat_n1", obs_rd[1], 32'h0);
`endif
    idle(); all_raddr(5'd3); cycle();
    check_val("lat_n2", obs_rd[2], 32'h1234_5678);

    // out-of-range write and read
    idle(); all_raddr(5'd28);
    we = 2'b11; waddr[0] = 5'd28; waddr[1] = 5'd31; wdata = '1; wbe = '1;
    cycle();
    idle(); all_raddr(5'd28); cycle();
    idle(); all_raddr(5'd28); cycle();
    check_val("oor_read28", obs_rd[0], 32'h0);
    read_all();

    // back-to-back byte merge on address 0
    idle(); all_raddr(5'd0);
    we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
    cycle();
    idle(); all_raddr(5'd0);
    we[1] = 1'b1; waddr[1] = 5'd0; wdata[1] = 32'h0000_0011; wbe[1] = 4'h1;
    cycle();
    idle(); all_raddr(5'd0); cycle();
    idle(); all_raddr(5'd0); cycle();
    check_val("b2b_addr0", obs_rd[0], 32'hFFFF_FF11);

    // random traffic
    repeat (400) begin rnd_in(); cycle(); end
    read_all();

    // reset while a write is staged, then a reset glitch at sweep count 10
    idle();
    we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hCAFE_F00D; wbe[0] = 4'hF;
    cycle();
    idle(); rst_n = 1'b0; cycle();
    release_wait(10);
    read_all();

    repeat (200) begin rnd_in(); cycle(); end
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
